cmp_operand_sequencer: RTL and testbench
========================================

Name: cmp_operand_sequencer

Overview:
Upstream/downstream controller for the 6-bit magnitude comparator (x >= y, 2-bit slice structure) in the Mini ALU. It accepts operands serially as 2-bit chunks over a valid/ready handshake, assembles X then Y, and drives them to the comparator. It then samples the comparator's single-bit result and holds it on a valid/ready output until consumed. It keeps a wrapping count of completed comparisons.

Parameters:
CHUNK_W, 2, width of one serial input chunk; matches the comparator's 2-bit slice
NCHUNK, 3, chunks per operand; operand width W = CHUNK_W*NCHUNK = 6
CNT_W, 8, width of the completed-comparison counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_data holds a valid chunk
in_data  input  CHUNK_W  operand chunk, LSB chunk first, X chunks then Y chunks
in_ready  output  1  sequencer accepts a chunk this cycle
x3  output  W  operand X to comparator (registered)
y3  output  W  operand Y to comparator (registered)
c3  input  1  comparator result (1 = x3 >= y3), combinational from x3/y3
out_valid  output  1  result available
out_ge  output  1  registered comparison result
out_ready  input  1  consumer accepts result
cmp_count  output  CNT_W  number of results consumed, wraps modulo 2^CNT_W

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high. Reset dominates every other input in the same cycle.
- Reset values: state=LOAD_X, chunk counter=0, x3=0, y3=0, out_ge=0, out_valid=0, in_ready=1, cmp_count=0.
- Chunk acceptance: a chunk transfers on a rising edge where in_valid && in_ready. When in_valid is low, no state changes.
- Shift rule: the accepted chunk enters bits [W-1:W-CHUNK_W]. The register shifts right by CHUNK_W. After NCHUNK accepts, the first chunk sits in [CHUNK_W-1:0].
- States:
  LOAD_X: in_ready=1. Each accept shifts into x3 and increments the counter. On accept with counter==NCHUNK-1, the counter goes to 0 and the state goes to LOAD_Y.
  LOAD_Y: in_ready=1. Each accept shifts into y3. On the last accept, the counter goes to 0 and the state goes to CMP.
  CMP: one cycle. in_ready=0 and x3/y3 are stable. At the end of this cycle, out_ge <= c3, out_valid <= 1, and the state goes to HOLD.
  HOLD: in_ready=0; out_valid=1; out_ge, x3 and y3 are held. On out_valid && out_ready, out_valid goes to 0, cmp_count increments (wrapping), and the state goes to LOAD_X.
- Latency: last Y chunk accepted at edge N; CMP during cycle N..N+1; out_valid high from edge N+1. Minimum turnaround is 2*NCHUNK + 2 cycles per comparison with no stalls.
- No skid path: in_ready deasserts in CMP/HOLD, so no chunk is accepted while a result is pending. Zero-stall back-to-back operation is not supported and not required.
- x3/y3 are not cleared between operations. Intermediate values during LOAD_* are don't-care to the comparator because c3 is sampled only in CMP.
- out_ready held high before out_valid has no effect. out_ge and out_valid must not change while out_valid=1 && !out_ready.
- cmp_count wraps from 2^CNT_W-1 to 0 with no saturation or flag.
- Reset mid-load or mid-HOLD discards the partial operand and any pending result; no output handshake occurs for it.

Decomposition:
- Shared package (mini_alu_pkg):
  - constants CHUNK_W, NCHUNK, W
  - state enum {LOAD_X, LOAD_Y, CMP, HOLD} encoded in 2 bits
- One natural sub-module: chunk_shift_reg (W-bit right-shift register with load-enable and synchronous reset), instantiated once each for X and Y.
- The comparator stays external; it is connected at the parent level via x3/y3/c3.

Test Plan:
- Chunks 01,11,10 then 00,11,10 (X=6'b101101=45, Y=6'b101100=44), out_ready=1 -> x3=45, y3=44, out_ge=1 at edge N+1, cmp_count=1.
- X=45, Y=45 -> out_ge=1. X=6'b010100 (20), Y=6'b010101 (21) -> out_ge=0. Both cases use a bench reference comparator model.
- in_valid toggles 1,0,0,1,… during loading -> only valid cycles shift; operands still assemble to 45/44; result timing is counted from the last accepted chunk.
- out_ready held low for 5 cycles in HOLD -> out_valid, out_ge, x3, y3 are stable, in_ready=0 and extra in_valid is ignored; the release completes one handshake and cmp_count increments by exactly 1.
- Assert reset after 2 X chunks, then load 20/21 -> outputs return to reset values the cycle after reset; the new result is out_ge=0 with no leftover bits from the aborted load.
- Run 257 back-to-back comparisons -> cmp_count=1 (wrapped); each result matches the reference model.

Source files
------------

// File: rtl/mini_alu_pkg.sv
// Shared constants and state encoding for the Mini ALU comparator operand sequencer.
package mini_alu_pkg;
  localparam int CHUNK_W     = 2;
  localparam int NCHUNK      = 3;
  localparam int W           = CHUNK_W * NCHUNK;
  localparam int CNT_W       = 8;
  localparam int CHUNK_CNT_W = $clog2(NCHUNK);

  typedef enum logic [1:0] {
    LOAD_X = 2'd0,
    LOAD_Y = 2'd1,
    CMP    = 2'd2,
    HOLD   = 2'd3
  } seq_state_e;
endpackage

// File: rtl/cmp_operand_sequencer_if.sv
// Chunk input, comparator link and result output of the operand sequencer.
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both
// high; the producer holds its data stable until then, and ready may depend on state only.
interface cmp_operand_sequencer_if;
  import mini_alu_pkg::*;

  logic               in_valid;
  logic [CHUNK_W-1:0] in_data;
  logic               in_ready;
  logic [W-1:0]       x3;
  logic [W-1:0]       y3;
  logic               c3;
  logic               out_valid;
  logic               out_ge;
  logic               out_ready;
  logic [CNT_W-1:0]   cmp_count;

  // master: the sequencer itself; slave: chunk source, comparator and result consumer
  modport master (
    input  in_valid, in_data, c3, out_ready,
    output in_ready, x3, y3, out_valid, out_ge, cmp_count
  );
  modport slave (
    output in_valid, in_data, c3, out_ready,
    input  in_ready, x3, y3, out_valid, out_ge, cmp_count
  );
endinterface

// File: rtl/cmp_operand_sequencer_chunk_shift_reg.sv
// W-bit right-shift register: each enabled cycle a new chunk enters at the MSB end.
module chunk_shift_reg
  import mini_alu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic [CHUNK_W-1:0] chunk_i,
  output logic [W-1:0]       q_o
);
  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) q_d = {chunk_i, q_q[W-1:CHUNK_W]};
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// File: rtl/cmp_operand_sequencer.sv
// Collects X then Y serially in CHUNK_W-bit pieces, drives them to the external
// comparator, captures its result and holds it on a valid/ready output until consumed.
module cmp_operand_sequencer
  import mini_alu_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  cmp_operand_sequencer_if.master   bus,
  output seq_state_e                state_o
);
  seq_state_e             state_q, state_d;
  logic [CHUNK_CNT_W-1:0] cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_ge_q, out_ge_d;
  logic [CNT_W-1:0]       cmp_count_q, cmp_count_d;
  logic                   accept;
  logic                   last_chunk;
  logic                   shift_x;
  logic                   shift_y;

  assign bus.in_ready = (state_q == LOAD_X) || (state_q == LOAD_Y);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_chunk   = (cnt_q == CHUNK_CNT_W'(NCHUNK - 1));
  assign shift_x      = accept && (state_q == LOAD_X);
  assign shift_y      = accept && (state_q == LOAD_Y);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_ge_d    = out_ge_q;
    cmp_count_d = cmp_count_q;
    case (state_q)
      LOAD_X, LOAD_Y: begin
        if (accept) begin
          if (last_chunk) begin
            cnt_d   = '0;
            state_d = (state_q == LOAD_X) ? LOAD_Y : CMP;
          end else begin
            cnt_d = cnt_q + CHUNK_CNT_W'(1);
          end
        end
      end
      // x3/y3 have been stable for a full cycle here, so c3 has settled
      CMP: begin
        out_ge_d    = bus.c3;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          cmp_count_d = cmp_count_q + CNT_W'(1);
          state_d     = LOAD_X;
        end
      end
      default: state_d = LOAD_X;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD_X;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_ge_q    <= 1'b0;
      cmp_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_ge_q    <= out_ge_d;
      cmp_count_q <= cmp_count_d;
    end
  end

  chunk_shift_reg u_x_reg (
    .clk     (clk),
    .reset   (reset),
    .en_i    (shift_x),
    .chunk_i (bus.in_data),
    .q_o     (bus.x3)
  );

  chunk_shift_reg u_y_reg (
    .clk     (clk),
    .reset   (reset),
    .en_i    (shift_y),
    .chunk_i (bus.in_data),
    .q_o     (bus.y3)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.out_ge    = out_ge_q;
  assign bus.cmp_count = cmp_count_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_cmp_operand_sequencer.sv
// Directed bench for cmp_operand_sequencer with an ideal x3 >= y3 comparator on c3.
module tb_cmp_operand_sequencer;
  import mini_alu_pkg::*;

  logic       clk;
  logic       reset;
  seq_state_e state;
  int         n_tests;
  int         n_fail;
  logic [7:0] exp_count;

  cmp_operand_sequencer_if bus ();

  cmp_operand_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state)
  );

  // external comparator
  assign bus.c3 = (bus.x3 >= bus.y3);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_chunk(input logic [1:0] c);
    bus.in_valid = 1'b1;
    bus.in_data  = c;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 2'b00;
  endtask

  task automatic load_ops(input logic [5:0] x, input logic [5:0] y, input int gap);
    logic [11:0] ops;
    ops = {y, x};
    for (int i = 0; i < 6; i++) begin
      send_chunk(ops[2*i +: 2]);
      if (i < 5) repeat (gap) tick();
    end
  endtask

  // Loads one operand pair, checks CMP cycle, result latency, and the output handshake.
  task automatic do_compare(input logic [5:0] x, input logic [5:0] y, input int gap,
                            input logic exp_ge, input string name);
    bus.out_ready = 1'b0;
    load_ops(x, y, gap);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || state !== CMP) begin
      n_fail++;
      $display("FAIL %s cmp_cycle: out_valid=%b in_ready=%b state=%0d, want 0 0 %0d",
               name, bus.out_valid, bus.in_ready, state, CMP);
    end
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_ge !== exp_ge) begin
      n_fail++;
      $display("FAIL %s result: out_valid=%b out_ge=%b, want 1 %b",
               name, bus.out_valid, bus.out_ge, exp_ge);
    end
    n_tests++;
    if (bus.x3 !== x || bus.y3 !== y) begin
      n_fail++;
      $display("FAIL %s operands: x3=%0d y3=%0d, want %0d %0d", name, bus.x3, bus.y3, x, y);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_count = exp_count + 8'd1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.cmp_count !== exp_count || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s handshake: out_valid=%b cmp_count=%0d in_ready=%b, want 0 %0d 1",
               name, bus.out_valid, bus.cmp_count, bus.in_ready, exp_count);
    end
  endtask

  task automatic apply_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 2'b00;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset     = 1'b0;
    exp_count = 8'd0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (state !== LOAD_X || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.out_ge !== 1'b0 || bus.x3 !== 6'd0 || bus.y3 !== 6'd0 || bus.cmp_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_values: state=%0d in_ready=%b out_valid=%b out_ge=%b x3=%0d y3=%0d cnt=%0d, want 0 1 0 0 0 0 0",
               state, bus.in_ready, bus.out_valid, bus.out_ge, bus.x3, bus.y3, bus.cmp_count);
    end
  endtask

  task automatic test_basic();
    do_compare(6'd45, 6'd44, 0, 1'b1, "basic_45_44");
    n_tests++;
    if (bus.cmp_count !== 8'd1) begin
      n_fail++;
      $display("FAIL basic_count: cmp_count=%0d, want 1", bus.cmp_count);
    end
  endtask

  task automatic test_equal_less();
    do_compare(6'd45, 6'd45, 0, 1'b1, "equal_45_45");
    do_compare(6'd20, 6'd21, 0, 1'b0, "less_20_21");
  endtask

  task automatic test_gaps();
    do_compare(6'd45, 6'd44, 2, 1'b1, "gaps_45_44");
  endtask

  task automatic test_hold_stall();
    bus.out_ready = 1'b0;
    load_ops(6'd50, 6'd10, 0);
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_ge !== 1'b1 || bus.x3 !== 6'd50 ||
          bus.y3 !== 6'd10 || bus.in_ready !== 1'b0 || state !== HOLD) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: out_valid=%b out_ge=%b x3=%0d y3=%0d in_ready=%b state=%0d, want 1 1 50 10 0 %0d",
                 i, bus.out_valid, bus.out_ge, bus.x3, bus.y3, bus.in_ready, state, HOLD);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_count = exp_count + 8'd1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.cmp_count !== exp_count || bus.x3 !== 6'd50 || bus.y3 !== 6'd10) begin
      n_fail++;
      $display("FAIL hold_release: out_valid=%b cmp_count=%0d x3=%0d y3=%0d, want 0 %0d 50 10",
               bus.out_valid, bus.cmp_count, bus.x3, bus.y3, exp_count);
    end
    tick();
    n_tests++;
    if (bus.cmp_count !== exp_count || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_single_count: cmp_count=%0d out_valid=%b, want %0d 0",
               bus.cmp_count, bus.out_valid, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    send_chunk(2'b11);
    send_chunk(2'b11);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    exp_count = 8'd0;
    n_tests++;
    if (state !== LOAD_X || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.out_ge !== 1'b0 || bus.x3 !== 6'd0 || bus.y3 !== 6'd0 || bus.cmp_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_values: state=%0d in_ready=%b out_valid=%b out_ge=%b x3=%0d y3=%0d cnt=%0d, want 0 1 0 0 0 0 0",
               state, bus.in_ready, bus.out_valid, bus.out_ge, bus.x3, bus.y3, bus.cmp_count);
    end
    do_compare(6'd20, 6'd21, 0, 1'b0, "reset_mid_20_21");
  endtask

  task automatic test_back_to_back();
    logic [5:0] x;
    logic [5:0] y;
    apply_reset();
    for (int i = 0; i < 257; i++) begin
      x = 6'(i);
      y = 6'(i * 7 + 3);
      do_compare(x, y, 0, (x >= y), "b2b");
    end
    n_tests++;
    if (bus.cmp_count !== 8'd1) begin
      n_fail++;
      $display("FAIL b2b_wrap: cmp_count=%0d, want 1", bus.cmp_count);
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    exp_count     = 8'd0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 2'b00;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_equal_less();
    test_gaps();
    test_hold_stall();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
